d_flip_flop_sync: RTL and testbench

// - Positive-edge-triggered D flip-flop bank with true and complementary outputs.
// - Synchronous, active-high reset and a configurable reset value.
// - Basic storage primitive for registers, pipeline stages and small state holders.
// - Default WIDTH=1 gives the classic single-bit DFF: i_d in, o_q/o_qn out.

---
 rtl/d_flip_flop_sync_pkg.sv | 9 +
 rtl/d_flip_flop_sync.sv | 44 ++++
 tb/tb_d_flip_flop_sync.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/d_flip_flop_sync_pkg.sv
// d_flip_flop_sync_pkg: shared default width, word type and reset value for the DFF bank
//   DFF_DEFAULT_WIDTH        default number of storage bits
//   dff_word_t               storage word at the default width
//   DFF_DEFAULT_RESET_VALUE  default reset value
package d_flip_flop_sync_pkg;
    localparam int DFF_DEFAULT_WIDTH = 1;
    typedef logic [DFF_DEFAULT_WIDTH-1:0] dff_word_t;
    localparam dff_word_t DFF_DEFAULT_RESET_VALUE = '0;
endpackage

// File: rtl/d_flip_flop_sync.sv
// d_flip_flop_sync: rising-edge D flip-flop bank with sync active-high reset and complement output
//   i_clk  clock, state changes on the rising edge only
//   i_rst  synchronous active-high reset, loads RESET_VALUE
//   i_en   load enable, present only with D_FLIP_FLOP_SYNC_ENABLE_EN defined
//   i_d    WIDTH-bit data input
//   o_q    stored value
//   o_qn   bitwise complement of o_q
module d_flip_flop_sync
    import d_flip_flop_sync_pkg::*;
#(
    parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DFF_DEFAULT_RESET_VALUE)
) (
    input  logic             i_clk,
    input  logic             i_rst,
`ifdef D_FLIP_FLOP_SYNC_ENABLE_EN
    input  logic             i_en,
`endif
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qn
);
    logic load;
`ifdef D_FLIP_FLOP_SYNC_ENABLE_EN
    assign load = i_en;
`else
    assign load = 1'b1;
`endif
    if (WIDTH < 1) begin : g_bad_width
        $error("d_flip_flop_sync: WIDTH must be >= 1");
    end
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_q <= RESET_VALUE;
        else if (load)
            o_q <= i_d;
    end
    // complement comes from the single register so the two outputs can never disagree
    assign o_qn = ~o_q;
    always @(posedge i_clk) begin
        if (!$isunknown(o_q))
            assert (o_qn === ~o_q);
    end
endmodule

// File: tb/tb_d_flip_flop_sync.sv
// tb_d_flip_flop_sync: table, hand-written and random checks of 1-bit and 8-bit DFF banks
module tb_d_flip_flop_sync;
    localparam logic [7:0] RST8 = 8'h3C;
    logic       clk;
    logic       rst;
    logic [7:0] d;
    logic [7:0] q8;
    logic [7:0] qn8;
    logic       q1;
    logic       qn1;
    int         n_chk = 0;
    int         n_fail = 0;
`ifdef D_FLIP_FLOP_SYNC_ENABLE_EN
    logic       en;
`endif
    d_flip_flop_sync #(.WIDTH(8), .RESET_VALUE(RST8)) dut8 (
        .i_clk(clk),
        .i_rst(rst),
`ifdef D_FLIP_FLOP_SYNC_ENABLE_EN
        .i_en(en),
`endif
        .i_d(d),
        .o_q(q8),
        .o_qn(qn8)
    );
    d_flip_flop_sync dut1 (
        .i_clk(clk),
        .i_rst(rst),
`ifdef D_FLIP_FLOP_SYNC_ENABLE_EN
        .i_en(en),
`endif
        .i_d(d[0:0]),
        .o_q(q1),
        .o_qn(qn1)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    typedef struct {
        logic       rst;
        logic [7:0] d;
        logic [7:0] q8;
        logic       q1;
    } vec_t;
    vec_t tbl[8];
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask
    task automatic chk_all(input string name, input logic [7:0] e8, input logic e1);
        chk({name, " q8"}, q8, e8);
        chk({name, " qn8"}, qn8, ~e8);
        chk({name, " q1"}, {7'b0, q1}, {7'b0, e1});
        chk({name, " qn1"}, {7'b0, qn1}, {7'b0, ~e1});
    endtask
    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask
    logic [7:0] m8;
    logic       m1;
    logic       en_eff;
    initial begin
        tbl[0] = '{1'b1, 8'hFF, RST8,  1'b0};
        tbl[1] = '{1'b0, 8'h00, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 8'hA5, 8'hA5, 1'b1};
        tbl[3] = '{1'b0, 8'h5A, 8'h5A, 1'b0};
        tbl[4] = '{1'b0, 8'hFF, 8'hFF, 1'b1};
        tbl[5] = '{1'b1, 8'h81, RST8,  1'b0};
        tbl[6] = '{1'b0, 8'h81, 8'h81, 1'b1};
        tbl[7] = '{1'b0, 8'h7E, 8'h7E, 1'b0};
`ifdef D_FLIP_FLOP_SYNC_ENABLE_EN
        en = 1'b1;
`endif
        rst = 1'b1;
        d = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            rst = tbl[i].rst;
            d = tbl[i].d;
            edge_wait();
            chk_all($sformatf("tbl[%0d]", i), tbl[i].q8, tbl[i].q1);
        end
        d = 8'h11;
        edge_wait();
        chk_all("load 11", 8'h11, 1'b1);
        d = 8'h22;
        #3;
        chk_all("no transparency a", 8'h11, 1'b1);
        d = 8'h33;
        #3;
        chk_all("no transparency b", 8'h11, 1'b1);
        edge_wait();
        chk_all("load after change", 8'h33, 1'b1);
        #3;
        rst = 1'b1;
        d = 8'h44;
        #3;
        chk_all("rst mid-cycle", 8'h33, 1'b1);
        edge_wait();
        chk_all("rst at edge", RST8, 1'b0);
        rst = 1'b0;
        d = 8'hFF;
        edge_wait();
        chk_all("rst release", 8'hFF, 1'b1);
`ifdef D_FLIP_FLOP_SYNC_ENABLE_EN
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = (i % 2 == 0) ? 8'h00 : 8'hC3;
            edge_wait();
            chk_all("en=0 hold", 8'hFF, 1'b1);
        end
        en = 1'b1;
        d = 8'h01;
        edge_wait();
        chk_all("en=1 load", 8'h01, 1'b1);
        en = 1'b0;
        rst = 1'b1;
        d = 8'hAA;
        edge_wait();
        chk_all("rst over en=0", RST8, 1'b0);
        rst = 1'b0;
`endif
        m8 = q8 === 8'hFF ? 8'hFF : RST8;
        m8 = 8'hFF;
        m1 = 1'b1;
`ifdef D_FLIP_FLOP_SYNC_ENABLE_EN
        m8 = RST8;
        m1 = 1'b0;
`endif
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 9) == 0);
            d = 8'($urandom);
            en_eff = 1'b1;
`ifdef D_FLIP_FLOP_SYNC_ENABLE_EN
            en = ($urandom_range(0, 3) != 0);
            en_eff = en;
`endif
            // reference: reset wins, otherwise the word is replaced only when loading
            if (rst) begin
                m8 = RST8;
                m1 = 1'b0;
            end else if (en_eff) begin
                m8 = d;
                m1 = d[0];
            end
            edge_wait();
            chk_all($sformatf("rand[%0d]", i), m8, m1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
